t_counter_ctrl: RTL and testbench

Sequencer for a bank of WIDTH toggle flip-flops forming a synchronous modulo-(MAX+1) up/down counter. It computes the per-bit toggle vector from the current count, direction and run state, and holds the T-FF bank internally (Q <= Q ^ T). An FSM handles start, pause and clear commands and one-shot termination. It sits between the board-level button and prescaler logic (start, pause, clear, tick) and the display and LED logic (q, busy, done, wrap).

---
 rtl/t_counter_ctrl.sv | 104 ++++++++++
 tb/tb_t_counter_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/t_counter_ctrl.sv
// Up/down modulo-(MAX+1) counter built from a bank of toggle flip-flops.
// An FSM sequences start/pause/clear commands and one-shot termination.
//
// state | meaning
// IDLE  | after reset or clear; count held, no stepping
// RUN   | qualified ticks step the count
// HOLD  | paused; count held until the next pause
// DONE  | one-shot run finished at a wrap; count held
module t_counter_ctrl #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             clk,
    input  logic             r,
    input  logic             tick,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             up_dn,
    input  logic             oneshot,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    state_t state, state_nxt;
    logic   step_ok;
    logic   wrap_evt;
    logic   carry;

    // Any command in the same cycle takes the tick's place.
    assign step_ok = (state == S_RUN) && tick && !clear && !start && !pause;

    always_comb begin
        t_vec    = '0;
        carry    = 1'b1;
        wrap_evt = 1'b0;
        if (step_ok) begin
            if (up_dn) begin
                if (q == MAX_V) begin
                    t_vec    = q;
                    wrap_evt = 1'b1;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        t_vec[i] = carry;
                        carry    = carry & q[i];
                    end
                end
            end else begin
                if (q == '0) begin
                    t_vec    = MAX_V;
                    wrap_evt = 1'b1;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        t_vec[i] = carry;
                        carry    = carry & ~q[i];
                    end
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_IDLE;
        end else if (start && (state == S_IDLE || state == S_DONE)) begin
            state_nxt = S_RUN;
        end else if (pause && state == S_RUN) begin
            state_nxt = S_HOLD;
        end else if (pause && state == S_HOLD) begin
            state_nxt = S_RUN;
        end else if (wrap_evt && oneshot) begin
            state_nxt = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state <= S_IDLE;
            q     <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= clear ? '0 : (q ^ t_vec);
            wrap  <= wrap_evt;
        end
    end

    assign busy = (state == S_RUN) || (state == S_HOLD);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_t_counter_ctrl.sv
// Scoreboard bench for t_counter_ctrl: a decimal (MAX=9) and a binary (MAX=15)
// instance share stimulus; an arithmetic count model predicts every cycle.
module tb_t_counter_ctrl;

    logic       clk = 1'b0;
    logic       r = 1'b0;
    logic       tick = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic       up_dn = 1'b1, oneshot = 1'b0;
    logic [3:0] t_vec0, q0, t_vec1, q1;
    logic       busy0, done0, wrap0, busy1, done1, wrap1;

    t_counter_ctrl #(.WIDTH(4), .MAX(9)) dut_dec (
        .clk(clk), .r(r), .tick(tick), .start(start), .pause(pause),
        .clear(clear), .up_dn(up_dn), .oneshot(oneshot),
        .t_vec(t_vec0), .q(q0), .busy(busy0), .done(done0), .wrap(wrap0)
    );

    t_counter_ctrl #(.WIDTH(4), .MAX(15)) dut_bin (
        .clk(clk), .r(r), .tick(tick), .start(start), .pause(pause),
        .clear(clear), .up_dn(up_dn), .oneshot(oneshot),
        .t_vec(t_vec1), .q(q1), .busy(busy1), .done(done1), .wrap(wrap1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int w;
        int busy;
        int done;
    } exp_t;

    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

    exp_t sb0[$];
    exp_t sb1[$];
    int   cnt[2];
    int   mode[2];
    int   mx[2] = '{9, 15};
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, check the combinational toggle vector, and
    // queue the state expected after the coming rising edge.
    task automatic step(input bit rr, input bit cl, input bit s, input bit pa,
                        input bit ti, input bit ud, input bit os);
        @(negedge clk);
        r = rr; clear = cl; start = s; pause = pa; tick = ti; up_dn = ud; oneshot = os;
        #1;
        for (int k = 0; k < 2; k++) begin
            int   old_c, new_c, w, ns;
            bit   qual;
            exp_t e;
            old_c = cnt[k];
            new_c = old_c;
            w     = 0;
            ns    = mode[k];
            qual  = rr && !cl && !s && !pa && ti && (mode[k] == M_RUN);
            if (!rr || cl) begin
                new_c = 0;
                ns    = M_IDLE;
            end else if (s) begin
                if (mode[k] == M_IDLE || mode[k] == M_DONE) ns = M_RUN;
            end else if (pa) begin
                if (mode[k] == M_RUN) ns = M_HOLD;
                else if (mode[k] == M_HOLD) ns = M_RUN;
            end else if (qual) begin
                if (ud) begin
                    if (old_c == mx[k]) begin new_c = 0; w = 1; end
                    else new_c = old_c + 1;
                end else begin
                    if (old_c == 0) begin new_c = mx[k]; w = 1; end
                    else new_c = old_c - 1;
                end
                if (w == 1 && os) ns = M_DONE;
            end
            chk($sformatf("t_vec[%0d] q=%0d", k, old_c),
                (k == 0) ? int'(t_vec0) : int'(t_vec1), qual ? (old_c ^ new_c) : 0);
            cnt[k]  = new_c;
            mode[k] = ns;
            e.q     = new_c;
            e.w     = w;
            e.busy  = (ns == M_RUN || ns == M_HOLD) ? 1 : 0;
            e.done  = (ns == M_DONE) ? 1 : 0;
            if (k == 0) sb0.push_back(e);
            else sb1.push_back(e);
        end
    endtask

    task automatic check_reset_now(input string tag);
        chk({tag, " q0"}, int'(q0), 0);
        chk({tag, " q1"}, int'(q1), 0);
        chk({tag, " busy0"}, int'(busy0), 0);
        chk({tag, " done0"}, int'(done0), 0);
        chk({tag, " wrap0"}, int'(wrap0), 0);
        chk({tag, " busy1"}, int'(busy1), 0);
        chk({tag, " t_vec0"}, int'(t_vec0), 0);
    endtask

    // Pull reset low between edges and verify it acts without a clock.
    task automatic async_reset();
        @(posedge clk);
        #2;
        r = 1'b0;
        #1;
        check_reset_now("async_rst");
        for (int k = 0; k < 2; k++) begin
            cnt[k]  = 0;
            mode[k] = M_IDLE;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
                chk("q dec", int'(q0), e.q);
                chk("wrap dec", int'(wrap0), e.w);
                chk("busy dec", int'(busy0), e.busy);
                chk("done dec", int'(done0), e.done);
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                chk("q bin", int'(q1), e.q);
                chk("wrap bin", int'(wrap1), e.w);
                chk("busy bin", int'(busy1), e.busy);
                chk("done bin", int'(done1), e.done);
            end
        end
    end

    initial begin : driver
        bit ud_r, os_r, cl, s, pa, ti;
        int rn;
        cnt  = '{0, 0};
        mode = '{M_IDLE, M_IDLE};
        #2;
        check_reset_now("power_on");
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 1, 1, 0);

        // up free-run through the decimal wrap
        step(1, 0, 1, 0, 0, 1, 0);
        repeat (12) step(1, 0, 0, 0, 1, 1, 0);

        // down one-shot from zero, then restart out of DONE
        step(1, 1, 0, 0, 0, 1, 0);
        step(1, 0, 1, 0, 0, 0, 1);
        repeat (4) step(1, 0, 0, 0, 1, 0, 1);
        step(1, 0, 1, 0, 0, 0, 1);

        // pause with a coincident tick, ticks ignored in HOLD, resume
        step(1, 1, 0, 0, 0, 1, 0);
        step(1, 0, 1, 0, 0, 1, 0);
        repeat (3) step(1, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 1, 0);
        repeat (5) step(1, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0, 1, 1, 0);

        // clear beats start and tick at q=7
        repeat (3) step(1, 0, 0, 0, 1, 1, 0);
        step(1, 1, 1, 0, 1, 1, 0);

        // 16 up ticks: full binary cycle on the MAX=15 instance
        step(1, 0, 1, 0, 0, 1, 0);
        repeat (16) step(1, 0, 0, 0, 1, 1, 0);

        // async reset at q=5 in RUN
        step(1, 1, 0, 0, 0, 1, 0);
        step(1, 0, 1, 0, 0, 1, 0);
        repeat (5) step(1, 0, 0, 0, 1, 1, 0);
        async_reset();
        step(0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 1, 1, 0);

        // randomized traffic
        ud_r = 1'b1;
        os_r = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) < 8) ud_r = ~ud_r;
            if ($urandom_range(0, 99) < 3) os_r = ~os_r;
            cl = ($urandom_range(0, 99) < 3);
            ti = ($urandom_range(0, 99) < 65);
            rn = $urandom_range(0, 99);
            s  = (rn < 6);
            pa = (rn >= 6 && rn < 11);
            if (cl && $urandom_range(0, 1) == 1) begin
                s  = 1'b1;
                pa = 1'b0;
            end
            if ($urandom_range(0, 999) < 5) begin
                async_reset();
                step(0, cl, s, pa, ti, ud_r, os_r);
            end else begin
                step(1, cl, s, pa, ti, ud_r, os_r);
            end
        end

        @(posedge clk);
        #2;
        chk("scoreboard drained dec", sb0.size(), 0);
        chk("scoreboard drained bin", sb1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
